// File: rtl/midi_uart_rx_fifo.sv
// MIDI 8N1 receiver with a show-ahead byte FIFO, framing-error pulse and sticky overrun flag.
// Optional build macro MIDI_RT_FILTER_EN drops system real-time bytes (F8..FF) before the FIFO.
module midi_uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 31250,
    parameter int OSR        = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          CLOCK_50,
    input  logic          reset_reg_N,
    input  logic          midi_rxd,
    input  logic          rd_en,
    input  logic          clr_err,
    output logic [7:0]    byte_out,
    output logic          byte_valid,
    output logic [LW-1:0] fifo_level,
    output logic          frame_err,
    output logic          overrun
);

    localparam int DIV = CLK_HZ / (BAUD * OSR);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OSR);
    localparam int PW  = $clog2(FIFO_DEPTH);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [OW-1:0] OS_MID   = OW'(OSR / 2 - 1);
    localparam logic [OW-1:0] OS_LAST  = OW'(OSR - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

`ifdef MIDI_RT_FILTER_EN
    function automatic logic is_realtime(input logic [7:0] b);
        return (b[7:3] == 5'b11111);
    endfunction
`endif

    logic          rx_meta_r;
    logic          rxs_r;
    state_t        state_r;
    logic [DW-1:0] div_cnt_r;
    logic [OW-1:0] os_cnt_r;
    logic [OW-1:0] idle_cnt_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          frame_err_r;

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          byte_valid_r;
    logic [7:0]    byte_out_r;
    logic          overrun_r;
    logic [7:0]    mem_r [FIFO_DEPTH];

    logic          os_tick_s;
    logic          mid_s;
    logic          rt_byte_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          wr_en_s;
    logic          drop_s;
    logic [PW-1:0] rd_ptr_next_s;
    logic [LW-1:0] level_next_s;
    logic [7:0]    head_next_s;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= midi_rxd;
            rxs_r     <= rx_meta_r;
        end
    end

    // Tick/mid-bit decode and FIFO push/pop arbitration
    always_comb begin
        os_tick_s = (div_cnt_r == DIV_LAST);
        mid_s     = os_tick_s && (os_cnt_r == OS_MID);
`ifdef MIDI_RT_FILTER_EN
        rt_byte_s = is_realtime(shift_r);
`else
        rt_byte_s = 1'b0;
`endif
        push_s  = (state_r == ST_STOP) && mid_s && rxs_r && !rt_byte_s;
        pop_s   = rd_en && (level_r != {LW{1'b0}});
        full_s  = (level_r == LVL_FULL);
        wr_en_s = push_s && (!full_s || pop_s);
        drop_s  = push_s && full_s && !pop_s;

        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        case ({wr_en_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase

        // A byte written into the slot that becomes the head bypasses the array
        if (wr_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = shift_r;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Receiver FSM with oversampling counters; os_cnt keeps running so it wraps on each bit boundary
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_r     <= ST_IDLE;
            div_cnt_r   <= {DW{1'b0}};
            os_cnt_r    <= {OW{1'b0}};
            idle_cnt_r  <= {OW{1'b0}};
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;

            if ((state_r == ST_IDLE) || os_tick_s) begin
                div_cnt_r <= {DW{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end

            if (state_r == ST_IDLE) begin
                os_cnt_r <= {OW{1'b0}};
            end else if (os_tick_s) begin
                os_cnt_r <= (os_cnt_r == OS_LAST) ? {OW{1'b0}} : os_cnt_r + OW'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    if (!rxs_r) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (mid_s) begin
                        if (!rxs_r) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (mid_s) begin
                        shift_r[bit_cnt_r] <= rxs_r;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (mid_s) begin
                        if (rxs_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            idle_cnt_r  <= {OW{1'b0}};
                            state_r     <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    // A break holds us here until a full bit time of idle line is seen
                    if (os_tick_s) begin
                        if (!rxs_r) begin
                            idle_cnt_r <= {OW{1'b0}};
                        end else if (idle_cnt_r == OS_LAST) begin
                            idle_cnt_r <= {OW{1'b0}};
                            state_r    <= ST_IDLE;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + OW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, level, registered head and sticky overrun (set beats clear)
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            level_r      <= {LW{1'b0}};
            byte_valid_r <= 1'b0;
            byte_out_r   <= 8'h00;
            overrun_r    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r     <= rd_ptr_next_s;
            level_r      <= level_next_s;
            byte_valid_r <= (level_next_s != {LW{1'b0}});
            byte_out_r   <= head_next_s;
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clr_err) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // Byte storage; contents are only meaningful between the pointers
    always_ff @(posedge CLOCK_50) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    assign byte_out   = byte_out_r;
    assign byte_valid = byte_valid_r;
    assign fifo_level = level_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_midi_uart_rx_fifo.sv
// Directed bench for midi_uart_rx_fifo: table of single-frame vectors plus hand-written multi-byte sequences.
// The DUT runs at CLK_HZ=5 MHz (200 ns clock) so each MIDI bit is 160 cycles at true 31250 baud.
`timescale 1ns/1ps
module tb_midi_uart_rx_fifo;

    localparam int NOM_NS  = 32000;
    localparam int FAST_NS = 31360;
    localparam int SLOW_NS = 32640;
`ifdef MIDI_RT_FILTER_EN
    localparam int RT_FILT = 1;
`else
    localparam int RT_FILT = 0;
`endif

    logic       CLOCK_50;
    logic       reset_reg_N;
    logic       midi_rxd;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [3:0] fifo_level;
    logic       frame_err;
    logic       overrun;

    int   checks;
    int   failures;
    int   ferr_cnt;
    int   ferr0;
    logic pre_stop_valid;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         bit_ns;
        logic [3:0] exp_level;
        logic [7:0] exp_head;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    midi_uart_rx_fifo #(
        .CLK_HZ(5000000), .BAUD(31250), .OSR(16), .FIFO_DEPTH(8)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_reg_N(reset_reg_N),
        .midi_rxd(midi_rxd),
        .rd_en(rd_en),
        .clr_err(clr_err),
        .byte_out(byte_out),
        .byte_valid(byte_valid),
        .fifo_level(fifo_level),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #100 CLOCK_50 = ~CLOCK_50;
    end

    always @(negedge CLOCK_50) begin
        if (frame_err === 1'b1) begin
            ferr_cnt <= ferr_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int bit_ns);
        midi_rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            midi_rxd = d[i];
            #(bit_ns);
        end
        midi_rxd = stop_bit;
        #(bit_ns / 4);
        pre_stop_valid = byte_valid;
        #(bit_ns - bit_ns / 4);
        midi_rxd = 1'b1;
    endtask

    task automatic pop();
        @(negedge CLOCK_50);
        rd_en = 1'b1;
        @(negedge CLOCK_50);
        rd_en = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        ferr_cnt    = 0;
        reset_reg_N = 1'b0;
        midi_rxd    = 1'b1;
        rd_en       = 1'b0;
        clr_err     = 1'b0;

        vecs[0] = '{8'h90, 1'b1, NOM_NS,  4'd1, 8'h90, 0};
        vecs[1] = '{8'h55, 1'b0, NOM_NS,  4'd0, 8'h00, 1};
        vecs[2] = '{8'hAA, 1'b1, NOM_NS,  4'd1, 8'hAA, 0};
        vecs[3] = '{8'hC3, 1'b1, FAST_NS, 4'd1, 8'hC3, 0};
        vecs[4] = '{8'hC3, 1'b1, SLOW_NS, 4'd1, 8'hC3, 0};
        vecs[5] = '{8'hF8, 1'b1, NOM_NS,  (RT_FILT != 0) ? 4'd0 : 4'd1, 8'hF8, 0};
        vecs[6] = '{8'hFF, 1'b1, NOM_NS,  (RT_FILT != 0) ? 4'd0 : 4'd1, 8'hFF, 0};
        vecs[7] = '{8'h00, 1'b1, NOM_NS,  4'd1, 8'h00, 0};

        // Reset state and an idle line for 1 ms
        repeat (5) @(negedge CLOCK_50);
        check("reset_valid", {31'd0, byte_valid}, 32'd0);
        check("reset_level", {28'd0, fifo_level}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        reset_reg_N = 1'b1;
        #1000000;
        @(negedge CLOCK_50);
        check("idle_valid", {31'd0, byte_valid}, 32'd0);
        check("idle_level", {28'd0, fifo_level}, 32'd0);
        check("idle_ferr", ferr_cnt, 32'd0);
        check("idle_overrun", {31'd0, overrun}, 32'd0);

        // 3 us low glitch must not start a frame
        midi_rxd = 1'b0;
        #3000;
        midi_rxd = 1'b1;
        #(2 * NOM_NS);
        @(negedge CLOCK_50);
        check("glitch_level", {28'd0, fifo_level}, 32'd0);
        check("glitch_valid", {31'd0, byte_valid}, 32'd0);
        check("glitch_ferr", ferr_cnt, 32'd0);

        // Note-on message, then three pops in order
        send_byte(8'h90, 1'b1, NOM_NS);
        check("msg_prestop_valid", {31'd0, pre_stop_valid}, 32'd0);
        send_byte(8'h3C, 1'b1, NOM_NS);
        send_byte(8'h64, 1'b1, NOM_NS);
        @(negedge CLOCK_50);
        check("msg_level", {28'd0, fifo_level}, 32'd3);
        check("msg_head0", {24'd0, byte_out}, 32'h90);
        pop();
        check("msg_level_after_pop", {28'd0, fifo_level}, 32'd2);
        check("msg_head1", {24'd0, byte_out}, 32'h3C);
        pop();
        check("msg_head2", {24'd0, byte_out}, 32'h64);
        check("msg_valid2", {31'd0, byte_valid}, 32'd1);
        pop();
        check("msg_valid_empty", {31'd0, byte_valid}, 32'd0);
        check("msg_level_empty", {28'd0, fifo_level}, 32'd0);
        pop();
        check("pop_empty_level", {28'd0, fifo_level}, 32'd0);

        // Single-frame vectors, each starting from an empty FIFO
        for (int v = 0; v < 8; v++) begin
            ferr0 = ferr_cnt;
            send_byte(vecs[v].data, vecs[v].stop_bit, vecs[v].bit_ns);
            #(2 * NOM_NS);
            @(negedge CLOCK_50);
            check($sformatf("vec%0d_prestop_valid", v), {31'd0, pre_stop_valid}, 32'd0);
            check($sformatf("vec%0d_level", v), {28'd0, fifo_level}, {28'd0, vecs[v].exp_level});
            check($sformatf("vec%0d_valid", v), {31'd0, byte_valid}, {31'd0, (vecs[v].exp_level != 4'd0)});
            check($sformatf("vec%0d_ferr", v), ferr_cnt - ferr0, vecs[v].exp_ferr);
            if (vecs[v].exp_level != 4'd0) begin
                check($sformatf("vec%0d_head", v), {24'd0, byte_out}, {24'd0, vecs[v].exp_head});
            end
            for (int j = 0; j < int'(vecs[v].exp_level); j++) begin
                pop();
            end
            check($sformatf("vec%0d_drained", v), {28'd0, fifo_level}, 32'd0);
        end

        // Ten bytes without pops: full at 8, then two dropped
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(i), 1'b1, NOM_NS);
            if (i == 7) begin
                @(negedge CLOCK_50);
                check("fill_level8", {28'd0, fifo_level}, 32'd8);
                check("fill_no_overrun", {31'd0, overrun}, 32'd0);
            end
        end
        #(NOM_NS);
        @(negedge CLOCK_50);
        check("ovr_level", {28'd0, fifo_level}, 32'd8);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_head", {24'd0, byte_out}, 32'h00);
        clr_err = 1'b1;
        @(negedge CLOCK_50);
        clr_err = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLOCK_50);
            check($sformatf("ovr_pop%0d", k), {24'd0, byte_out}, k);
            rd_en = 1'b1;
            @(negedge CLOCK_50);
            rd_en = 1'b0;
        end
        check("ovr_drained_valid", {31'd0, byte_valid}, 32'd0);
        check("ovr_drained_level", {28'd0, fifo_level}, 32'd0);

        // Real-time byte followed by a status byte
        send_byte(8'hF8, 1'b1, NOM_NS);
        send_byte(8'h90, 1'b1, NOM_NS);
        @(negedge CLOCK_50);
        check("rt_level", {28'd0, fifo_level}, (RT_FILT != 0) ? 32'd1 : 32'd2);
        check("rt_head", {24'd0, byte_out}, (RT_FILT != 0) ? 32'h90 : 32'hF8);

        // Reset during a frame (8'hF0): released while the remaining bits are high
        ferr0 = ferr_cnt;
        midi_rxd = 1'b0;
        #(2 * NOM_NS);
        #(NOM_NS / 2);
        reset_reg_N = 1'b0;
        #(NOM_NS / 2);
        #(NOM_NS);
        check("midreset_level", {28'd0, fifo_level}, 32'd0);
        check("midreset_valid", {31'd0, byte_valid}, 32'd0);
        #(NOM_NS);
        midi_rxd = 1'b1;
        #(NOM_NS / 2);
        reset_reg_N = 1'b1;
        #(NOM_NS / 2);
        #(6 * NOM_NS);
        @(negedge CLOCK_50);
        check("postreset_level", {28'd0, fifo_level}, 32'd0);
        check("postreset_valid", {31'd0, byte_valid}, 32'd0);
        check("postreset_ferr", ferr_cnt - ferr0, 32'd0);
        check("postreset_overrun", {31'd0, overrun}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
